// File: rtl/hls_cnn_2d_100s_mac_pkg.sv
// Shared types and width helpers for the hls_cnn_2d_100s MAC pipeline.
// Product width, saturation bounds and the beat sideband live here.
package hls_cnn_2d_100s_mac_pkg;

    typedef struct packed {
        logic acc_en;
        logic first;
        logic last;
    } sideband_t;

    function automatic int prod_width(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

    // Bounds are returned 64 bits wide; callers keep the low ACC_WIDTH bits.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/hls_cnn_2d_100s_mul_pipe.sv
// Signed x signed/unsigned multiplier with NUM_STAGE ce-gated registers.
// The beat sideband and valid bit travel alongside the product.
module hls_cnn_2d_100s_mul_pipe
    import hls_cnn_2d_100s_mac_pkg::*;
#(
    parameter int DIN0_WIDTH  = 16,
    parameter int DIN1_WIDTH  = 12,
    parameter int DIN1_SIGNED = 0,
    parameter int NUM_STAGE   = 2,
    localparam int PW = prod_width(DIN0_WIDTH, DIN1_WIDTH)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  in_valid,
    input  sideband_t             in_sb,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    output sideband_t             out_sb,
    output logic [PW-1:0]         out_prod
);

    logic                 w_b_msb;
    logic signed [PW:0]   w_a;
    logic signed [PW:0]   w_b;
    logic signed [PW:0]   w_full;
    sideband_t            w_sb;

    logic [NUM_STAGE-1:0] r_vld;
    sideband_t            r_sb   [NUM_STAGE];
    logic [PW-1:0]        r_prod [NUM_STAGE];

    // Unsigned weights get a zero sign bit so one signed multiply covers both.
    assign w_b_msb = (DIN1_SIGNED != 0) ? din1[DIN1_WIDTH-1] : 1'b0;
    assign w_a     = {{(DIN1_WIDTH + 1){din0[DIN0_WIDTH-1]}}, din0};
    assign w_b     = {{(DIN0_WIDTH + 1){w_b_msb}}, din1};
    assign w_full  = w_a * w_b;
    assign w_sb    = in_valid ? in_sb : '0;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_vld <= '0;
            for (int i = 0; i < NUM_STAGE; i++) begin
                r_sb[i]   <= '0;
                r_prod[i] <= '0;
            end
        end else if (ce) begin
            r_vld[0]  <= in_valid;
            r_sb[0]   <= w_sb;
            r_prod[0] <= w_full[PW-1:0];
            for (int i = 1; i < NUM_STAGE; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_sb[i]   <= r_sb[i-1];
                r_prod[i] <= r_prod[i-1];
            end
        end
    end

    assign out_valid = r_vld[NUM_STAGE-1];
    assign out_sb    = r_sb[NUM_STAGE-1];
    assign out_prod  = r_prod[NUM_STAGE-1];

endmodule

// File: rtl/hls_cnn_2d_100s_mac_pipe.sv
// Pipelined MAC: multiplier pipe plus one accumulate/output stage.
// Define HLS_CNN_MAC_SAT_EN for saturating accumulation with sticky overflow.
module hls_cnn_2d_100s_mac_pipe
    import hls_cnn_2d_100s_mac_pkg::*;
#(
    parameter int DIN0_WIDTH  = 16,
    parameter int DIN1_WIDTH  = 12,
    parameter int DIN1_SIGNED = 0,
    parameter int NUM_STAGE   = 2,
    parameter int ACC_WIDTH   = 40
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic                  acc_en,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    output logic [ACC_WIDTH-1:0]  dout,
    output logic                  dout_ovf
);

    localparam int PW = prod_width(DIN0_WIDTH, DIN1_WIDTH);

    sideband_t                    w_in_sb;
    sideband_t                    w_sb;
    logic                         w_vld;
    logic [PW-1:0]                w_prod;
    logic signed [ACC_WIDTH-1:0]  w_prod_ext;
    logic signed [ACC_WIDTH-1:0]  w_base;
    logic signed [ACC_WIDTH-1:0]  w_sum;
    logic signed [ACC_WIDTH-1:0]  w_acc_nxt;

    logic [ACC_WIDTH-1:0]         r_acc;
    logic [ACC_WIDTH-1:0]         r_dout;
    logic                         r_out_valid;

    assign w_in_sb = '{acc_en: acc_en, first: in_first, last: in_last};

    hls_cnn_2d_100s_mul_pipe #(
        .DIN0_WIDTH  (DIN0_WIDTH),
        .DIN1_WIDTH  (DIN1_WIDTH),
        .DIN1_SIGNED (DIN1_SIGNED),
        .NUM_STAGE   (NUM_STAGE)
    ) u_mul (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_sb     (w_in_sb),
        .din0      (din0),
        .din1      (din1),
        .out_valid (w_vld),
        .out_sb    (w_sb),
        .out_prod  (w_prod)
    );

    assign w_prod_ext = ACC_WIDTH'($signed(w_prod));
    assign w_base     = w_sb.first ? '0 : $signed(r_acc);
    assign w_sum      = w_base + w_prod_ext;

`ifdef HLS_CNN_MAC_SAT_EN
    localparam logic [63:0] SAT_POS = sat_max(ACC_WIDTH);
    localparam logic [63:0] SAT_NEG = sat_min(ACC_WIDTH);

    logic w_ovf;
    logic w_sticky_nxt;
    logic r_sticky;
    logic r_ovf_q;

    // Same-sign operands producing a different-sign sum is the only overflow.
    assign w_ovf = (w_base[ACC_WIDTH-1] == w_prod_ext[ACC_WIDTH-1]) &&
                   (w_sum[ACC_WIDTH-1] != w_base[ACC_WIDTH-1]);
    assign w_acc_nxt = !w_ovf ? w_sum :
                       w_base[ACC_WIDTH-1] ? $signed(SAT_NEG[ACC_WIDTH-1:0]) :
                                             $signed(SAT_POS[ACC_WIDTH-1:0]);
    assign w_sticky_nxt = (w_sb.first ? 1'b0 : r_sticky) | w_ovf;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_sticky <= 1'b0;
            r_ovf_q  <= 1'b0;
        end else if (ce && w_vld) begin
            if (w_sb.acc_en) begin
                r_sticky <= w_sticky_nxt;
                if (w_sb.last) begin
                    r_ovf_q <= w_sticky_nxt;
                end
            end else begin
                r_ovf_q <= 1'b0;
            end
        end
    end

    assign dout_ovf = r_out_valid & r_ovf_q;
`else
    assign w_acc_nxt = w_sum;
    assign dout_ovf  = 1'b0;
`endif

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_acc       <= '0;
            r_dout      <= '0;
            r_out_valid <= 1'b0;
        end else if (ce) begin
            r_out_valid <= 1'b0;
            if (w_vld) begin
                if (w_sb.acc_en) begin
                    r_acc <= w_acc_nxt;
                    if (w_sb.last) begin
                        r_dout      <= w_acc_nxt;
                        r_out_valid <= 1'b1;
                    end
                end else begin
                    r_dout      <= w_prod_ext;
                    r_out_valid <= 1'b1;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign dout      = r_dout;

endmodule
